// File: rtl/lc_ctrl_trans_fsm.sv
// -----------------------------------------------------------------------------
// lc_ctrl_trans_fsm
//
// Lifecycle transition controller. Accepts one transition request at a time,
// checks the requested target encoding and legality against the current
// lifecycle state, waits TokenWait cycles for the token check, then either
// commits the new state or rejects the request.
//
// Ports
//   clk_i           clock, all flops update on the rising edge
//   rst_i           synchronous active-high reset
//   trans_valid_i   transition request valid
//   trans_ready_o   high only in Idle; request accepted on valid && ready
//   trans_target_i  requested lifecycle state (two 2-bit words)
//   token_ok_i      token-check result, sampled once per request
//   state_o         registered lifecycle state
//   trans_done_o    one-cycle pulse when a transition commits
//   trans_err_o     one-cycle pulse when a request is rejected
//   fatal_o         sticky fault flag (invalid target encoding seen)
//   trans_cnt_o     saturating count of committed transitions
// -----------------------------------------------------------------------------
module lc_ctrl_trans_fsm #(
   parameter logic [3:0] ResetState = 4'b0101,
   parameter int         TokenWait  = 4
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       trans_valid_i,
   output logic       trans_ready_o,
   input  logic [3:0] trans_target_i,
   input  logic       token_ok_i,
   output logic [3:0] state_o,
   output logic       trans_done_o,
   output logic       trans_err_o,
   output logic       fatal_o,
   output logic [4:0] trans_cnt_o
);

   localparam logic [1:0] B0 = 2'b01;
   localparam logic [1:0] B1 = 2'b10;

   localparam logic [3:0] LcStRaw          = {B0, B0};
   localparam logic [3:0] LcStTestUnlocked = {B0, B1};
   localparam logic [3:0] LcStProd         = {B1, B1};
   localparam logic [3:0] LcStScrap        = {B1, B0};

   localparam logic [7:0] WaitLoad = 8'(TokenWait - 1);

   typedef enum logic [2:0] {
      FsmIdle,
      FsmCheck,
      FsmWait,
      FsmCommit,
      FsmError
   } fsm_e;

   fsm_e       fsmQ, fsmD;
   logic [3:0] targetQ, targetD;
   logic [7:0] waitCntQ, waitCntD;
   logic [3:0] stateQ, stateD;
   logic       fatalQ, fatalD;
   logic [4:0] cntQ, cntD;

   function automatic logic isValidEnc(input logic [3:0] enc);
      return (enc == LcStRaw) || (enc == LcStTestUnlocked) ||
             (enc == LcStProd) || (enc == LcStScrap);
   endfunction

   // Scrap is terminal; every other pair not listed here is illegal.
   function automatic logic isLegal(input logic [3:0] curSt, input logic [3:0] nxtSt);
      return ((curSt == LcStRaw)          && ((nxtSt == LcStTestUnlocked) || (nxtSt == LcStScrap))) ||
             ((curSt == LcStTestUnlocked) && ((nxtSt == LcStProd)         || (nxtSt == LcStScrap))) ||
             ((curSt == LcStProd)         &&  (nxtSt == LcStScrap));
   endfunction

   function automatic logic [4:0] satInc(input logic [4:0] v);
      return (v == 5'd31) ? v : v + 5'd1;
   endfunction

   always_comb begin
      fsmD     = fsmQ;
      targetD  = targetQ;
      waitCntD = waitCntQ;
      stateD   = stateQ;
      fatalD   = fatalQ;
      cntD     = cntQ;
      unique case (fsmQ)
         FsmIdle: begin
            if (trans_valid_i) begin
               targetD = trans_target_i;
               fsmD    = FsmCheck;
            end
         end
         FsmCheck: begin
            if (!isValidEnc(targetQ)) begin
               // A corrupted target encoding forces the part into Scrap.
               fatalD  = 1'b1;
               targetD = LcStScrap;
               fsmD    = FsmCommit;
            end else if (isLegal(stateQ, targetQ)) begin
               waitCntD = WaitLoad;
               fsmD     = FsmWait;
            end else begin
               fsmD = FsmError;
            end
         end
         FsmWait: begin
            // token_ok_i is only looked at on the final wait cycle.
            if (waitCntQ == 8'd0) begin
               fsmD = token_ok_i ? FsmCommit : FsmError;
            end else begin
               waitCntD = waitCntQ - 8'd1;
            end
         end
         FsmCommit: begin
            stateD = targetQ;
            cntD   = satInc(cntQ);
            fsmD   = FsmIdle;
         end
         FsmError: begin
            fsmD = FsmIdle;
         end
         default: begin
            fsmD = FsmIdle;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         fsmQ     <= FsmIdle;
         waitCntQ <= 8'd0;
         stateQ   <= ResetState;
         fatalQ   <= 1'b0;
         cntQ     <= 5'd0;
      end else begin
         fsmQ     <= fsmD;
         waitCntQ <= waitCntD;
         stateQ   <= stateD;
         fatalQ   <= fatalD;
         cntQ     <= cntD;
      end
   end

   // The latched target is pure data: it is always rewritten on acceptance.
   always_ff @(posedge clk_i) begin
      targetQ <= targetD;
   end

   assign trans_ready_o = (fsmQ == FsmIdle);
   assign trans_done_o  = (fsmQ == FsmCommit);
   assign trans_err_o   = (fsmQ == FsmError);
   assign state_o       = stateQ;
   assign fatal_o       = fatalQ;
   assign trans_cnt_o   = cntQ;

endmodule

// File: tb/tb_lc_ctrl_trans_fsm.sv
module tb_lc_ctrl_trans_fsm;

   localparam int         TW       = 4;
   localparam logic [3:0] RST_ST   = 4'b0101;
   localparam logic [3:0] ST_RAW   = 4'b0101;
   localparam logic [3:0] ST_TU    = 4'b0110;
   localparam logic [3:0] ST_PROD  = 4'b1010;
   localparam logic [3:0] ST_SCRAP = 4'b1001;
   localparam int         WINDOW   = TW + 4;

   logic       clk_i = 1'b0;
   logic       rst_i = 1'b1;
   logic       trans_valid_i = 1'b0;
   logic       trans_ready_o;
   logic [3:0] trans_target_i = 4'h0;
   logic       token_ok_i = 1'b0;
   logic [3:0] state_o;
   logic       trans_done_o;
   logic       trans_err_o;
   logic       fatal_o;
   logic [4:0] trans_cnt_o;

   lc_ctrl_trans_fsm #(
      .ResetState(RST_ST),
      .TokenWait (TW)
   ) dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .trans_valid_i (trans_valid_i),
      .trans_ready_o (trans_ready_o),
      .trans_target_i(trans_target_i),
      .token_ok_i    (token_ok_i),
      .state_o       (state_o),
      .trans_done_o  (trans_done_o),
      .trans_err_o   (trans_err_o),
      .fatal_o       (fatal_o),
      .trans_cnt_o   (trans_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   int nCompared   = 0;
   int nMismatched = 0;

   // Reference model: lifecycle state, commit count, sticky fault.
   logic [3:0] mState;
   int         mCnt;
   bit         mFatal;
   logic [3:0] ePrevState;
   int         eDoneAt, eErrAt;
   logic [7:0] legalPairs [5] = '{8'h56, 8'h59, 8'h6A, 8'h69, 8'hA9};

   // Observations of one request, cycle offsets relative to acceptance T.
   int         oDoneAt, oErrAt, oDone, oErr, oBoth, oFatalAt, oAccept;
   logic [3:0] stateHist [0:WINDOW];

   initial begin
      #500us;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic model_reset();
      mState = RST_ST;
      mCnt   = 0;
      mFatal = 1'b0;
   endtask

   function automatic bit modelLegal(input logic [3:0] cur, input logic [3:0] tgt);
      bit ok = 1'b0;
      foreach (legalPairs[i]) if ({cur, tgt} == legalPairs[i]) ok = 1'b1;
      return ok;
   endfunction

   task automatic predict(input logic [3:0] tgt, input logic tok);
      eDoneAt    = -1;
      eErrAt     = -1;
      ePrevState = mState;
      if (!(tgt inside {ST_RAW, ST_TU, ST_PROD, ST_SCRAP})) begin
         eDoneAt = 2;
         mState  = ST_SCRAP;
         mFatal  = 1'b1;
         mCnt    = (mCnt < 31) ? mCnt + 1 : 31;
      end else if (!modelLegal(mState, tgt)) begin
         eErrAt = 2;
      end else if (!tok) begin
         eErrAt = 2 + TW;
      end else begin
         eDoneAt = 2 + TW;
         mState  = tgt;
         mCnt    = (mCnt < 31) ? mCnt + 1 : 31;
      end
   endtask

   task automatic do_reset();
      rst_i = 1'b1;
      trans_valid_i = 1'b0;
      step();
      step();
      rst_i = 1'b0;
      model_reset();
   endtask

   // Present one request in the current cycle (T) and observe WINDOW cycles.
   task automatic do_request(input logic [3:0] tgt, input logic tokSample,
                             input bit randTok, input bit holdValid);
      trans_valid_i  = 1'b1;
      trans_target_i = tgt;
      token_ok_i     = ~tokSample;
      oAccept  = (trans_valid_i && trans_ready_o) ? 1 : 0;
      oDoneAt  = -1; oErrAt = -1; oDone = 0; oErr = 0; oBoth = 0; oFatalAt = -1;
      stateHist[0] = state_o;
      for (int k = 1; k <= WINDOW; k++) begin
         step();
         trans_valid_i  = (holdValid && k <= 1 + TW) ? 1'b1 : 1'b0;
         trans_target_i = 4'($urandom);
         if (k == 1 + TW) token_ok_i = tokSample;
         else             token_ok_i = randTok ? 1'($urandom) : ~tokSample;
         if (trans_valid_i && trans_ready_o) oAccept++;
         stateHist[k] = state_o;
         if (trans_done_o) begin oDone++; if (oDoneAt < 0) oDoneAt = k; end
         if (trans_err_o)  begin oErr++;  if (oErrAt < 0)  oErrAt  = k; end
         if (trans_done_o && trans_err_o) oBoth++;
         if (fatal_o && oFatalAt < 0) oFatalAt = k;
      end
      trans_valid_i = 1'b0;
      token_ok_i    = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      nCompared++;
      if (state_o !== RST_ST) begin nMismatched++; $display("FAIL reset_state: got %h expected %h", state_o, RST_ST); end
      nCompared++;
      if (trans_cnt_o !== 5'd0) begin nMismatched++; $display("FAIL reset_cnt: got %0d expected 0", trans_cnt_o); end
      nCompared++;
      if ({fatal_o, trans_done_o, trans_err_o} !== 3'b000) begin
         nMismatched++; $display("FAIL reset_flags: got fatal/done/err=%b expected 000", {fatal_o, trans_done_o, trans_err_o});
      end
      nCompared++;
      if (trans_ready_o !== 1'b1) begin nMismatched++; $display("FAIL reset_ready: got %b expected 1", trans_ready_o); end
   endtask

   task automatic test_legal_path();
      do_reset();
      predict(ST_TU, 1'b1);
      do_request(ST_TU, 1'b1, 1'b0, 1'b0);
      nCompared++;
      if (oDoneAt !== eDoneAt || oDone !== 1) begin
         nMismatched++; $display("FAIL legal_done: got T+%0d (x%0d) expected T+%0d (x1)", oDoneAt, oDone, eDoneAt);
      end
      nCompared++;
      if (oErrAt !== -1) begin nMismatched++; $display("FAIL legal_no_err: got err at T+%0d expected none", oErrAt); end
      nCompared++;
      if (stateHist[eDoneAt] !== ePrevState || stateHist[eDoneAt + 1] !== mState) begin
         nMismatched++;
         $display("FAIL legal_state_latency: got %h then %h expected %h then %h",
                  stateHist[eDoneAt], stateHist[eDoneAt + 1], ePrevState, mState);
      end
      nCompared++;
      if (trans_cnt_o !== 5'(mCnt)) begin nMismatched++; $display("FAIL legal_cnt: got %0d expected %0d", trans_cnt_o, mCnt); end
   endtask

   task automatic test_illegal();
      do_reset();
      predict(ST_PROD, 1'b1);
      do_request(ST_PROD, 1'b1, 1'b0, 1'b0);
      nCompared++;
      if (oErrAt !== eErrAt || oErr !== 1 || oDone !== 0) begin
         nMismatched++; $display("FAIL illegal_err: got err T+%0d x%0d done x%0d expected err T+%0d x1 done x0", oErrAt, oErr, oDone, eErrAt);
      end
      nCompared++;
      if (state_o !== mState || trans_cnt_o !== 5'(mCnt)) begin
         nMismatched++; $display("FAIL illegal_unchanged: got state %h cnt %0d expected %h %0d", state_o, trans_cnt_o, mState, mCnt);
      end
   endtask

   task automatic test_token_fail();
      do_reset();
      predict(ST_TU, 1'b0);
      do_request(ST_TU, 1'b0, 1'b0, 1'b0);
      nCompared++;
      if (oErrAt !== eErrAt || oDone !== 0) begin
         nMismatched++; $display("FAIL token_fail_err: got err T+%0d done x%0d expected err T+%0d done x0", oErrAt, oDone, eErrAt);
      end
      nCompared++;
      if (state_o !== mState || trans_cnt_o !== 5'(mCnt)) begin
         nMismatched++; $display("FAIL token_fail_state: got %h cnt %0d expected %h %0d", state_o, trans_cnt_o, mState, mCnt);
      end
   endtask

   task automatic test_invalid_encoding();
      do_reset();
      predict(4'b0000, 1'b1);
      do_request(4'b0000, 1'b1, 1'b0, 1'b0);
      nCompared++;
      if (oFatalAt !== 2 || oDoneAt !== eDoneAt) begin
         nMismatched++; $display("FAIL invalid_fatal_done: got fatal T+%0d done T+%0d expected T+2 and T+%0d", oFatalAt, oDoneAt, eDoneAt);
      end
      nCompared++;
      if (state_o !== mState || fatal_o !== 1'b1) begin
         nMismatched++; $display("FAIL invalid_scrap: got state %h fatal %b expected %h 1", state_o, fatal_o, mState);
      end
      predict(ST_RAW, 1'b1);
      do_request(ST_RAW, 1'b1, 1'b0, 1'b0);
      nCompared++;
      if (oErrAt !== eErrAt || oDone !== 0 || fatal_o !== 1'b1) begin
         nMismatched++; $display("FAIL invalid_then_reject: got err T+%0d done x%0d fatal %b expected err T+%0d done x0 fatal 1",
                                 oErrAt, oDone, fatal_o, eErrAt);
      end
   endtask

   task automatic test_reset_mid_wait();
      int pulses;
      do_reset();
      pulses = 0;
      trans_valid_i  = 1'b1;
      trans_target_i = ST_TU;
      token_ok_i     = 1'b1;
      step();
      trans_valid_i = 1'b0;
      for (int k = 2; k <= 3; k++) begin
         step();
         if (trans_done_o || trans_err_o) pulses++;
      end
      rst_i = 1'b1;
      step();
      rst_i = 1'b0;
      model_reset();
      nCompared++;
      if (trans_ready_o !== 1'b1 || state_o !== RST_ST || trans_cnt_o !== 5'd0) begin
         nMismatched++; $display("FAIL midwait_after_reset: got ready %b state %h cnt %0d expected 1 %h 0", trans_ready_o, state_o, trans_cnt_o, RST_ST);
      end
      for (int k = 0; k < TW + 4; k++) begin
         if (trans_done_o || trans_err_o) pulses++;
         step();
      end
      nCompared++;
      if (pulses !== 0 || state_o !== RST_ST) begin
         nMismatched++; $display("FAIL midwait_no_pulse: got %0d pulses state %h expected 0 pulses %h", pulses, state_o, RST_ST);
      end
   endtask

   task automatic test_chain_handshake();
      logic [3:0] chain [3] = '{ST_TU, ST_PROD, ST_SCRAP};
      do_reset();
      foreach (chain[i]) begin
         predict(chain[i], 1'b1);
         do_request(chain[i], 1'b1, 1'b0, 1'b1);
         nCompared++;
         if (oAccept !== 1 || oDoneAt !== eDoneAt) begin
            nMismatched++; $display("FAIL chain_step%0d: got accepts %0d done T+%0d expected 1 and T+%0d", i, oAccept, oDoneAt, eDoneAt);
         end
      end
      nCompared++;
      if (trans_cnt_o !== 5'(mCnt) || state_o !== mState) begin
         nMismatched++; $display("FAIL chain_final: got cnt %0d state %h expected %0d %h", trans_cnt_o, state_o, mCnt, mState);
      end
   endtask

   task automatic test_saturate();
      do_reset();
      for (int i = 0; i < 33; i++) begin
         predict(4'b0000, 1'b1);
         do_request(4'b0000, 1'b1, 1'b1, 1'b0);
      end
      nCompared++;
      if (trans_cnt_o !== 5'(mCnt) || mCnt != 31) begin
         nMismatched++; $display("FAIL cnt_saturate: got %0d expected %0d", trans_cnt_o, mCnt);
      end
   endtask

   task automatic test_random();
      logic [3:0] validSet [4] = '{ST_RAW, ST_TU, ST_PROD, ST_SCRAP};
      logic [3:0] tgt;
      logic       tok;
      do_reset();
      for (int n = 0; n < 40; n++) begin
         if ($urandom_range(9) == 0) do_reset();
         if ($urandom_range(9) < 7) tgt = validSet[$urandom_range(3)];
         else                       tgt = 4'($urandom);
         tok = 1'($urandom);
         predict(tgt, tok);
         do_request(tgt, tok, 1'b1, 1'b0);
         nCompared++;
         if (oDoneAt !== eDoneAt || oErrAt !== eErrAt || oBoth !== 0 || oAccept !== 1) begin
            nMismatched++;
            $display("FAIL rand%0d_pulses: tgt %h tok %b got done T+%0d err T+%0d both %0d acc %0d expected done T+%0d err T+%0d both 0 acc 1",
                     n, tgt, tok, oDoneAt, oErrAt, oBoth, oAccept, eDoneAt, eErrAt);
         end
         nCompared++;
         if (state_o !== mState || trans_cnt_o !== 5'(mCnt) || fatal_o !== mFatal || trans_ready_o !== 1'b1) begin
            nMismatched++;
            $display("FAIL rand%0d_state: got state %h cnt %0d fatal %b ready %b expected %h %0d %b 1",
                     n, state_o, trans_cnt_o, fatal_o, trans_ready_o, mState, mCnt, mFatal);
         end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_legal_path();
      test_illegal();
      test_token_fail();
      test_invalid_encoding();
      test_reset_mid_wait();
      test_chain_handshake();
      test_saturate();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
